// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for the scanned 7-segment receiver: multiplexed display inputs and decoded frame outputs.
// The SEG7_DP_EN macro adds the active-low decimal point input and its per-digit frame mask.
interface seg7_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    err_clr;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    frame_valid;
  logic                    err;
`ifdef SEG7_DP_EN
  logic                    dp;
  logic [NUM_DIGITS-1:0]   dp_mask;

  modport master (output seg, dig_sel, err_clr, dp,
                  input  value, blank_mask, frame_valid, err, dp_mask);
  modport slave  (input  seg, dig_sel, err_clr, dp,
                  output value, blank_mask, frame_valid, err, dp_mask);
`else
  modport master (output seg, dig_sel, err_clr,
                  input  value, blank_mask, frame_valid, err);
  modport slave  (input  seg, dig_sel, err_clr,
                  output value, blank_mask, frame_valid, err);
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// Debounces a time-multiplexed active-low 7-segment bus and reassembles NUM_DIGITS hex nibbles per frame.
// Optional decimal-point capture is enabled with the SEG7_DP_EN macro.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seg7_scan_decoder_if.slave   bus
);

  localparam int unsigned NW = 4 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
`ifdef SEG7_DP_EN
  localparam int unsigned SW = NUM_DIGITS + 8;
`else
  localparam int unsigned SW = NUM_DIGITS + 7;
`endif

  logic [SW-1:0]         in_c, samp_q;
  logic [CW-1:0]         cnt_q, cnt_nxt_c;
  logic                  changed_c, accept_c, onehot_c, multi_c;
  logic [3:0]            dec_nib_c;
  logic                  dec_ok_c, dec_blank_c;
  logic                  wr_c, err_evt_c, frame_done_c;
  logic [NUM_DIGITS-1:0] wr_mask_c;
  logic [NW-1:0]         wr_mask4_c;

  logic [NUM_DIGITS-1:0] seen_q, seen_nxt_c;
  logic [NW-1:0]         sh_val_q, sh_val_nxt_c;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_nxt_c;
  logic [NW-1:0]         value_q;
  logic [NUM_DIGITS-1:0] blank_q;
  logic                  fv_q, err_q, err_nxt_c;

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_nxt_c, dp_mask_q;
  assign in_c = {bus.dig_sel, bus.dp, bus.seg};
`else
  assign in_c = {bus.dig_sel, bus.seg};
`endif

  // Debounce: an accept fires only on the edge where the run length first reaches STABLE_CYCLES
  always_comb begin
    changed_c = (in_c != samp_q);
    cnt_nxt_c = cnt_q;
    if (changed_c)
      cnt_nxt_c = CW'(1);
    else if (cnt_q != CW'(STABLE_CYCLES))
      cnt_nxt_c = cnt_q + CW'(1);
    accept_c = (cnt_nxt_c == CW'(STABLE_CYCLES)) && (changed_c || (cnt_q != CW'(STABLE_CYCLES)));
    onehot_c = $onehot(bus.dig_sel);
    multi_c  = (|bus.dig_sel) && !onehot_c;
  end

  // Inverse of the hex encoder table; all-off is blank, anything else is invalid
  always_comb begin
    dec_nib_c   = 4'h0;
    dec_ok_c    = 1'b1;
    dec_blank_c = 1'b0;
    case (bus.seg)
      7'b1000000: dec_nib_c = 4'h0;
      7'b1111001: dec_nib_c = 4'h1;
      7'b0100100: dec_nib_c = 4'h2;
      7'b0110000: dec_nib_c = 4'h3;
      7'b0011001: dec_nib_c = 4'h4;
      7'b0010010: dec_nib_c = 4'h5;
      7'b0000010: dec_nib_c = 4'h6;
      7'b1111000: dec_nib_c = 4'h7;
      7'b0000000: dec_nib_c = 4'h8;
      7'b0010000: dec_nib_c = 4'h9;
      7'b0001000: dec_nib_c = 4'hA;
      7'b0000011: dec_nib_c = 4'hB;
      7'b1000110: dec_nib_c = 4'hC;
      7'b0100001: dec_nib_c = 4'hD;
      7'b0000110: dec_nib_c = 4'hE;
      7'b0001110: dec_nib_c = 4'hF;
      7'b1111111: dec_blank_c = 1'b1;
      default:    dec_ok_c = 1'b0;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_mask
      assign wr_mask4_c[4*g +: 4] = {4{wr_mask_c[g]}};
    end
  endgenerate

  // Shadow/seen update; a completing frame clears seen in the same edge a new digit may land
  always_comb begin
    wr_c           = accept_c && onehot_c && dec_ok_c;
    err_evt_c      = accept_c && (multi_c || (onehot_c && !dec_ok_c));
    wr_mask_c      = wr_c ? bus.dig_sel : '0;
    frame_done_c   = &seen_q;
    seen_nxt_c     = (frame_done_c ? '0 : seen_q) | wr_mask_c;
    sh_val_nxt_c   = (sh_val_q & ~wr_mask4_c) | (wr_mask4_c & {NUM_DIGITS{dec_nib_c}});
    sh_blank_nxt_c = (sh_blank_q & ~wr_mask_c) | (wr_mask_c & {NUM_DIGITS{dec_blank_c}});
`ifdef SEG7_DP_EN
    sh_dp_nxt_c    = (sh_dp_q & ~wr_mask_c) | (wr_mask_c & {NUM_DIGITS{~bus.dp}});
`endif
    err_nxt_c      = err_q;
    if (err_evt_c)
      err_nxt_c = 1'b1;
    else if (bus.err_clr)
      err_nxt_c = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_q     <= '0;
      cnt_q      <= '0;
      seen_q     <= '0;
      sh_val_q   <= '0;
      sh_blank_q <= '0;
      value_q    <= '0;
      blank_q    <= '1;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
`ifdef SEG7_DP_EN
      sh_dp_q    <= '0;
      dp_mask_q  <= '0;
`endif
    end else begin
      samp_q     <= in_c;
      cnt_q      <= cnt_nxt_c;
      seen_q     <= seen_nxt_c;
      sh_val_q   <= sh_val_nxt_c;
      sh_blank_q <= sh_blank_nxt_c;
      fv_q       <= frame_done_c;
      err_q      <= err_nxt_c;
`ifdef SEG7_DP_EN
      sh_dp_q    <= sh_dp_nxt_c;
`endif
      if (frame_done_c) begin
        value_q   <= sh_val_q;
        blank_q   <= sh_blank_q;
`ifdef SEG7_DP_EN
        dp_mask_q <= sh_dp_q;
`endif
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.blank_mask  = blank_q;
  assign bus.frame_valid = fv_q;
  assign bus.err         = err_q;
`ifdef SEG7_DP_EN
  assign bus.dp_mask     = dp_mask_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=3); dp checks build under SEG7_DP_EN.
module tb_seg7_scan_decoder;

  localparam logic [6:0] S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000, S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] BLK = 7'b1111111, BAD = 7'b1010101;

  bit   clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fv_cnt = 0;

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    bus.dig_sel = d;
    bus.seg     = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.dig_sel = 4'b0000;
    bus.seg     = BLK;
    bus.err_clr = 1'b0;
`ifdef SEG7_DP_EN
    bus.dp      = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check("rst_value", 32'(bus.value), 32'h0);
    check("rst_blank", 32'(bus.blank_mask), 32'hF);
    check("rst_fv", 32'(bus.frame_valid), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
`ifdef SEG7_DP_EN
    check("rst_dp_mask", 32'(bus.dp_mask), 32'h0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // basic frame with latency check on the last digit
    hold(4'b0001, S1, 4);
    hold(4'b0010, S2, 4);
    hold(4'b0100, S3, 4);
    hold(4'b1000, S4, 3);
    check("f1_fv_early", 32'(bus.frame_valid), 32'h0);
    @(negedge clk);
    check("f1_fv_pulse", 32'(bus.frame_valid), 32'h1);
    check("f1_value", 32'(bus.value), 32'h4321);
    check("f1_blank", 32'(bus.blank_mask), 32'h0);
    @(negedge clk);
    check("f1_fv_end", 32'(bus.frame_valid), 32'h0);
    hold(4'b0000, BLK, 3);
    check("f1_fv_count", 32'(fv_cnt), 32'd1);
    check("f1_err", 32'(bus.err), 32'h0);

    // debounce: a 2-cycle digit 1 is rejected, a 3-cycle one completes the frame
    hold(4'b0001, S5, 4);
    hold(4'b0010, S6, 2);
    hold(4'b0000, BLK, 2);
    hold(4'b0100, S7, 4);
    hold(4'b1000, S8, 4);
    hold(4'b0000, BLK, 3);
    check("deb_no_frame", 32'(fv_cnt), 32'd1);
    hold(4'b0010, S6, 3);
    hold(4'b0000, BLK, 3);
    check("deb_frame", 32'(fv_cnt), 32'd2);
    check("deb_value", 32'(bus.value), 32'h8765);

    // invalid pattern on digit 2
    hold(4'b0001, SC, 4);
    hold(4'b0010, SD, 4);
    hold(4'b0100, BAD, 4);
    hold(4'b1000, SF, 4);
    hold(4'b0000, BLK, 3);
    check("inv_err", 32'(bus.err), 32'h1);
    check("inv_no_frame", 32'(fv_cnt), 32'd2);
    hold(4'b0100, SE, 4);
    hold(4'b0000, BLK, 3);
    check("inv_resend_frame", 32'(fv_cnt), 32'd3);
    check("inv_value", 32'(bus.value), 32'hFEDC);
    check("inv_err_sticky", 32'(bus.err), 32'h1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("clr_err", 32'(bus.err), 32'h0);
    bus.err_clr = 1'b1;
    hold(4'b0001, BAD, 3);
    check("clr_vs_err", 32'(bus.err), 32'h1);
    bus.err_clr = 1'b0;
    hold(4'b0000, BLK, 2);
    check("clr_vs_err_hold", 32'(bus.err), 32'h1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;

    // multi-hot strobe, then a frame with a blank digit
    hold(4'b0011, S1, 4);
    check("multi_err", 32'(bus.err), 32'h1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    hold(4'b0001, S1, 4);
    hold(4'b0010, S2, 4);
    hold(4'b0100, S3, 4);
    hold(4'b1000, BLK, 4);
    hold(4'b0000, BLK, 3);
    check("blank_frame", 32'(fv_cnt), 32'd4);
    check("blank_value", 32'(bus.value), 32'h0321);
    check("blank_mask", 32'(bus.blank_mask), 32'h8);
    check("multi_no_err_after_clr", 32'(bus.err), 32'h0);

    // reset mid-frame discards digits 0 and 1
    hold(4'b0001, BAD, 4);
    hold(4'b0001, S5, 4);
    hold(4'b0010, S5, 4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_value", 32'(bus.value), 32'h0);
    check("mid_rst_blank", 32'(bus.blank_mask), 32'hF);
    check("mid_rst_err", 32'(bus.err), 32'h0);
    check("mid_rst_fv", 32'(bus.frame_valid), 32'h0);
    hold(4'b0000, BLK, 2);
    reset_n = 1'b1;
    @(negedge clk);
    hold(4'b0100, SA, 4);
    hold(4'b1000, SB, 4);
    hold(4'b0000, BLK, 3);
    check("mid_rst_discard", 32'(fv_cnt), 32'd4);
    hold(4'b0001, S8, 4);
    hold(4'b0010, S9, 4);
    hold(4'b0000, BLK, 3);
    check("post_rst_frame", 32'(fv_cnt), 32'd5);
    check("post_rst_value", 32'(bus.value), 32'hBA98);
    check("post_rst_blank", 32'(bus.blank_mask), 32'h0);

`ifdef SEG7_DP_EN
    bus.dp = 1'b0;
    hold(4'b0001, S1, 4);
    bus.dp = 1'b1;
    hold(4'b0010, S2, 4);
    hold(4'b0100, S3, 4);
    hold(4'b1000, S4, 4);
    hold(4'b0000, BLK, 3);
    check("dp_frame", 32'(fv_cnt), 32'd6);
    check("dp_mask", 32'(bus.dp_mask), 32'h1);
    check("dp_value", 32'(bus.value), 32'h4321);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the team's hex-to-7-segment encoder.
- Samples a time-multiplexed, active-low 7-segment bus (segment lines plus one-hot digit strobes), debounces each digit pattern, and decodes it back to a 4-bit hex nibble.
- Assembles NUM_DIGITS nibbles into one frame word.
- Used for display loopback checking and for reading scanned displays from external boards.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits per frame (1..8).
- STABLE_CYCLES, 3: consecutive identical samples required before a pattern is accepted (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- seg  input  7  active-low segments; bit0=a ... bit6=g (0 -> 7'b1000000, 1 -> 7'b1111001).
- dig_sel  input  NUM_DIGITS  active-high digit strobe; bit i selects digit i.
- err_clr  input  1  synchronous clear of err.
- value  output  4*NUM_DIGITS  last complete frame; digit i in bits [4i+3:4i].
- blank_mask  output  NUM_DIGITS  bit i set if digit i was blank (seg=7'b1111111) in the last frame.
- frame_valid  output  1  one-cycle pulse when value/blank_mask update.
- err  output  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release): value=0, blank_mask=all ones, frame_valid=0, err=0. Internal sample register, stability counter, seen mask and shadow frame all cleared.
- Sampling: {dig_sel, seg} is registered every cycle.
- Stability counter: increments (saturating at STABLE_CYCLES) while the new sample equals the registered one, and reloads to 1 on any change.
- Accept: a sample is accepted once, on the edge where the counter reaches STABLE_CYCLES. A run that stays stable longer is not re-accepted.
- dig_sel=0: idle. The counter still runs, but nothing is accepted.
- dig_sel with more than one bit set: on accept, err is set and no digit is updated.
- Decode on accept:
  - The 16 encoder codes map to nibbles 0-F. Table: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
  - 7'b1111111 is blank: nibble 0, shadow blank bit set.
  - Any other code is invalid: err is set, and neither the shadow nor the seen mask is updated.
- Frame assembly:
  - A valid or blank accept for digit i writes shadow slot i and sets seen[i].
  - Re-accepting a digit before the frame completes overwrites its slot without error.
  - When seen becomes all ones, on the next edge: value<=shadow, blank_mask<=shadow blanks, frame_valid=1 for exactly one cycle, seen cleared.
- Latency: inputs held stable from before edge k are accepted at edge k+STABLE_CYCLES-1. frame_valid follows on the next edge.
- err: set by any error event and cleared by err_clr. An error event in the same cycle as err_clr wins (err stays 1).
- Reset mid-frame discards partial shadow/seen contents. No frame_valid is produced for that frame.

Optional Feature:
- Macro: SEG7_DP_EN.
- Defined:
  - Adds input dp (1, active-low decimal point) and output dp_mask (NUM_DIGITS).
  - dp is sampled and stability-checked together with seg.
  - dp_mask bit i is set if dp was 0 on digit i's accept, and updates with value. Reset value 0.
  - dp does not affect decode validity.
- Undefined: no dp or dp_mask ports; behaviour otherwise identical.

Test Plan:
- Frame decode: NUM_DIGITS=4, STABLE_CYCLES=3; drive digits 0..3 with 1111001, 0100100, 0110000, 0011001, 4 cycles each -> one frame_valid pulse, value=16'h4321, blank_mask=4'b0000, err=0.
- Debounce: digit 1 pattern held only 2 cycles, then dig_sel=0 -> not accepted, no frame_valid; holding it 3 cycles completes the frame.
- Invalid pattern: digit 2 seg=7'b1010101 held 4 cycles -> err=1, no frame_valid until digit 2 is resent validly; err_clr then clears err, and err_clr concurrent with a new invalid accept leaves err=1.
- Multi-hot and blank: dig_sel=4'b0011 stable -> err=1. Full frame with digit 3 seg=7'b1111111 -> value[15:12]=0, blank_mask=4'b1000.
- Reset mid-frame: reset_n low after digits 0-1 accepted -> outputs at reset values. A subsequent complete frame 8,9,A,b (0000000, 0010000, 0001000, 0000011) -> value=16'hBA98.
- SEG7_DP_EN: dp=0 on digit 0 only -> dp_mask=4'b0001 at frame_valid.
